// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - CPU cell request bus and external memory port bundle
interface cpu_bus_arbiter_if #(
  parameter int CPU_QUANTITY = 4,
  parameter int ADDR_SIZE    = 32,
  parameter int DATA_SIZE    = 32
);
  logic [CPU_QUANTITY-1:0]           cpu_read_q;
  logic [CPU_QUANTITY-1:0]           cpu_write_q;
  logic [CPU_QUANTITY*ADDR_SIZE-1:0] cpu_addr;
  logic [CPU_QUANTITY*DATA_SIZE-1:0] cpu_data;
  logic                              rw_halt_in;
  logic [CPU_QUANTITY-1:0]           grant;
  logic [CPU_QUANTITY-1:0]           cpu_read_dn;
  logic [CPU_QUANTITY-1:0]           cpu_write_dn;
  logic [DATA_SIZE-1:0]              cpu_data_out;
  logic                              bus_err;
  logic                              bus_busy;
  logic [ADDR_SIZE-1:0]              mem_addr;
  logic [DATA_SIZE-1:0]              mem_data_out;
  logic                              mem_read_q;
  logic                              mem_write_q;
  logic [DATA_SIZE-1:0]              mem_data_in;
  logic                              mem_read_dn;
  logic                              mem_write_dn;

  // Arbiter side
  modport master (
    input  cpu_read_q, cpu_write_q, cpu_addr, cpu_data, rw_halt_in,
    input  mem_data_in, mem_read_dn, mem_write_dn,
    output grant, cpu_read_dn, cpu_write_dn, cpu_data_out, bus_err, bus_busy,
    output mem_addr, mem_data_out, mem_read_q, mem_write_q
  );

  // CPU cell array and memory side
  modport slave (
    output cpu_read_q, cpu_write_q, cpu_addr, cpu_data, rw_halt_in,
    output mem_data_in, mem_read_dn, mem_write_dn,
    input  grant, cpu_read_dn, cpu_write_dn, cpu_data_out, bus_err, bus_busy,
    input  mem_addr, mem_data_out, mem_read_q, mem_write_q
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - round-robin sequencer sharing one memory port among CPU cells
module cpu_bus_arbiter #(
  parameter int CPU_QUANTITY   = 4,
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  cpu_bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(CPU_QUANTITY);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d, owner_q, owner_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_SIZE-1:0]    addr_q, addr_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CPU_QUANTITY-1:0] grant_q, grant_d;
  logic [CPU_QUANTITY-1:0] read_dn_q, read_dn_d, write_dn_q, write_dn_d;
  logic                    mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic                    bus_err_q, bus_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [CPU_QUANTITY-1:0] req;
  logic [IDX_W-1:0]        cand, win;
  logic                    found, done_match, timed_out;

  assign req        = bus.cpu_read_q | bus.cpu_write_q;
  assign done_match = op_wr_q ? bus.mem_write_dn : bus.mem_read_dn;
  assign timed_out  = !bus.rw_halt_in && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Scan ptr+1 .. ptr so the last owner has lowest priority
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int i = 1; i <= CPU_QUANTITY; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % CPU_QUANTITY);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    grant_d    = grant_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    cnt_d      = cnt_q;
    read_dn_d  = '0;
    write_dn_d = '0;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found && !bus.rw_halt_in) begin
          owner_d  = win;
          op_wr_d  = bus.cpu_write_q[win];
          addr_d   = bus.cpu_addr[int'(win)*ADDR_SIZE +: ADDR_SIZE];
          wdata_d  = bus.cpu_data[int'(win)*DATA_SIZE +: DATA_SIZE];
          grant_d  = CPU_QUANTITY'(1) << win;
          mem_wr_d = bus.cpu_write_q[win];
          mem_rd_d = !bus.cpu_write_q[win];
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_match || timed_out) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          bus_err_d = !done_match;
          if (op_wr_q) begin
            write_dn_d = grant_q;
          end else begin
            read_dn_d = grant_q;
            rdata_d   = done_match ? bus.mem_data_in : '1;
          end
          state_d = ST_RELEASE;
        end else if (!bus.rw_halt_in && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        // Four-phase: owner must drop its request before the bus is freed
        if (!req[owner_q]) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(CPU_QUANTITY - 1);
      owner_q    <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      grant_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      cnt_q      <= '0;
      read_dn_q  <= '0;
      write_dn_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      grant_q    <= grant_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      cnt_q      <= cnt_d;
      read_dn_q  <= read_dn_d;
      write_dn_q <= write_dn_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.cpu_read_dn  = read_dn_q;
  assign bus.cpu_write_dn = write_dn_q;
  assign bus.cpu_data_out = rdata_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.bus_busy     = (state_q != ST_IDLE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_data_out = wdata_q;
  assign bus.mem_read_q   = mem_rd_q;
  assign bus.mem_write_q  = mem_wr_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;
  localparam int N = 4;
  localparam int A = 32;
  localparam int D = 32;
  localparam int T = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter_if #(.CPU_QUANTITY(N), .ADDR_SIZE(A), .DATA_SIZE(D)) bus ();

  cpu_bus_arbiter #(
    .CPU_QUANTITY(N), .ADDR_SIZE(A), .DATA_SIZE(D), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic serve_read(input logic [N-1:0] exp_g, input logic [D-1:0] rdata, input int lat);
    int t = 0;
    while (bus.grant == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("grant", bus.grant, exp_g);
    repeat (lat) @(negedge clk);
    bus.mem_data_in = rdata;
    bus.mem_read_dn = 1'b1;
    @(negedge clk);
    bus.mem_read_dn = 1'b0;
    check_eq("read_dn", bus.cpu_read_dn, exp_g);
    check_eq("rdata", bus.cpu_data_out, rdata);
    check_eq("mem_read_q_drop", bus.mem_read_q, 0);
    bus.cpu_read_q = bus.cpu_read_q & ~bus.grant;
    @(negedge clk);
    check_eq("read_dn_one_cycle", bus.cpu_read_dn, 0);
    check_eq("release_grant", bus.grant, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.cpu_read_q   = '0;
    bus.cpu_write_q  = '0;
    bus.cpu_addr     = '0;
    bus.cpu_data     = '0;
    bus.rw_halt_in   = 1'b0;
    bus.mem_data_in  = '0;
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_busy", bus.bus_busy, 0);
    check_eq("rst_mem_q", {bus.mem_read_q, bus.mem_write_q}, 0);
    check_eq("rst_data_out", bus.cpu_data_out, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single read from cell 2
    bus.cpu_addr[2*A +: A] = 32'h40;
    bus.cpu_read_q = 4'b0100;
    @(negedge clk);
    check_eq("t1_grant_latency", bus.grant, 4'b0100);
    check_eq("t1_mem_read_q", bus.mem_read_q, 1);
    check_eq("t1_mem_addr", bus.mem_addr, 32'h40);
    check_eq("t1_busy", bus.bus_busy, 1);
    serve_read(4'b0100, 32'hA5A5, 2);
    check_eq("t1_idle", bus.bus_busy, 0);

    // 2: round-robin order 0,1,3 then 0 again
    do_reset();
    bus.cpu_read_q = 4'b1011;
    serve_read(4'b0001, 32'h11, 0);
    bus.cpu_read_q[0] = 1'b1;
    serve_read(4'b0010, 32'h22, 0);
    serve_read(4'b1000, 32'h33, 1);
    serve_read(4'b0001, 32'h44, 0);

    // 3: write timeout
    bus.cpu_addr[1*A +: A] = 32'h10;
    bus.cpu_data[1*D +: D] = 32'h1234;
    bus.cpu_write_q = 4'b0010;
    @(negedge clk);
    check_eq("t3_grant", bus.grant, 4'b0010);
    check_eq("t3_mem_write_q", bus.mem_write_q, 1);
    check_eq("t3_mem_addr", bus.mem_addr, 32'h10);
    check_eq("t3_mem_data", bus.mem_data_out, 32'h1234);
    repeat (T - 1) @(negedge clk);
    check_eq("t3_before_timeout", bus.mem_write_q, 1);
    @(negedge clk);
    check_eq("t3_timeout_drop", bus.mem_write_q, 0);
    check_eq("t3_write_dn", bus.cpu_write_dn, 4'b0010);
    check_eq("t3_bus_err", bus.bus_err, 1);
    bus.cpu_write_q = '0;
    @(negedge clk);
    check_eq("t3_err_one_cycle", bus.bus_err, 0);
    check_eq("t3_dn_one_cycle", bus.cpu_write_dn, 0);
    check_eq("t3_release", bus.grant, 0);

    // 4: halt blocks grant and freezes timeout
    bus.rw_halt_in = 1'b1;
    bus.cpu_read_q = 4'b0001;
    repeat (3) @(negedge clk);
    check_eq("t4_halt_no_grant", bus.grant, 0);
    check_eq("t4_halt_idle", bus.bus_busy, 0);
    bus.rw_halt_in = 1'b0;
    @(negedge clk);
    check_eq("t4_grant_after_halt", bus.grant, 4'b0001);
    bus.rw_halt_in = 1'b1;
    repeat (T + 45) @(negedge clk);
    check_eq("t4_frozen_mem_q", bus.mem_read_q, 1);
    check_eq("t4_frozen_no_err", bus.bus_err, 0);
    check_eq("t4_frozen_no_dn", bus.cpu_read_dn, 0);
    bus.rw_halt_in = 1'b0;
    serve_read(4'b0001, 32'hC3C3, 0);

    // 5: async reset mid-transaction
    bus.cpu_read_q = 4'b1000;
    @(negedge clk);
    check_eq("t5_grant", bus.grant, 4'b1000);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_async_grant", bus.grant, 0);
    check_eq("t5_async_mem_q", bus.mem_read_q, 0);
    check_eq("t5_async_busy", bus.bus_busy, 0);
    check_eq("t5_async_data", bus.cpu_data_out, 0);
    bus.cpu_read_q = 4'b1001;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_cell0_first", bus.grant, 4'b0001);
    serve_read(4'b0001, 32'h5A, 0);
    serve_read(4'b1000, 32'h77, 0);

    // 6: mismatched done ignored, write wins over read, simultaneous dones
    bus.cpu_data[0 +: D] = 32'hBEEF;
    bus.cpu_read_q  = 4'b0001;
    bus.cpu_write_q = 4'b0001;
    @(negedge clk);
    check_eq("t6_grant", bus.grant, 4'b0001);
    check_eq("t6_write_wins", {bus.mem_read_q, bus.mem_write_q}, 2'b01);
    check_eq("t6_mem_data", bus.mem_data_out, 32'hBEEF);
    bus.mem_data_in = 32'hDEAD;
    bus.mem_read_dn = 1'b1;
    @(negedge clk);
    bus.mem_read_dn = 1'b0;
    check_eq("t6_ignored_rd_dn", bus.cpu_read_dn, 0);
    check_eq("t6_ignored_wr_dn", bus.cpu_write_dn, 0);
    check_eq("t6_still_writing", bus.mem_write_q, 1);
    bus.mem_read_dn  = 1'b1;
    bus.mem_write_dn = 1'b1;
    @(negedge clk);
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
    check_eq("t6_write_dn", bus.cpu_write_dn, 4'b0001);
    check_eq("t6_no_read_dn", bus.cpu_read_dn, 0);
    check_eq("t6_data_held", bus.cpu_data_out, 32'h77);
    check_eq("t6_no_err", bus.bus_err, 0);
    bus.cpu_read_q  = '0;
    bus.cpu_write_q = '0;
    @(negedge clk);
    check_eq("t6_release", bus.grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
